// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the program-counter sequencer: jump selects, FSM states
// and default field widths.
package pc_sequencer_pkg;

  localparam int DEF_PC_W  = 10;
  localparam int DEF_OFF_W = 16;
  localparam int DEF_TGT_W = 26;

  typedef enum logic [1:0] {
    JUMP_SEQ = 2'b00,
    JUMP_IMM = 2'b01,
    JUMP_REG = 2'b10,
    JUMP_RSV = 2'b11
  } jump_e;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_HALT    = 2'b01,
    ST_WAIT_IN = 2'b10
  } seq_state_e;

endpackage

// File: rtl/pc_sequencer_next_mux.sv
// Combinational next-pc selection for ordinary RUN instructions: jump, branch
// or sequential, plus the pc+1 link value.
module pc_next_mux
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W  = DEF_PC_W,
  parameter int OFF_W = DEF_OFF_W,
  parameter int TGT_W = DEF_TGT_W
) (
  input  logic [PC_W-1:0]  i_pc,
  input  logic [1:0]       i_jump,
  input  logic             i_branch,
  input  logic             i_brCond,
  input  logic [OFF_W-1:0] i_brOffset,
  input  logic [TGT_W-1:0] i_jmpTarget,
  input  logic [31:0]      i_rsData,
  output logic [PC_W-1:0]  o_pcPlus1,
  output logic [PC_W-1:0]  o_pcTarget
);

  logic [PC_W-1:0] w_offset;
  logic            w_unused;

  // Offset is sign-extended (or truncated) to pc width; the add wraps naturally.
  assign w_offset  = PC_W'($signed(i_brOffset));
  assign o_pcPlus1 = i_pc + PC_W'(1);
  assign w_unused  = ^{i_rsData[31:PC_W], i_jmpTarget[TGT_W-1:PC_W]};

  always_comb begin
    o_pcTarget = o_pcPlus1;
    case (jump_e'(i_jump))
      JUMP_IMM: o_pcTarget = i_jmpTarget[PC_W-1:0];
      JUMP_REG: o_pcTarget = i_rsData[PC_W-1:0];
      default: begin
        if (i_branch && i_brCond) begin
          o_pcTarget = o_pcPlus1 + w_offset;
        end
      end
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and RUN/HALT/WAIT_IN sequencing; drives the stall qualifier
// that freezes datapath writes and counts retired instructions.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W  = DEF_PC_W,
  parameter int OFF_W = DEF_OFF_W,
  parameter int TGT_W = DEF_TGT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       cu_Jump,
  input  logic             cu_Branch,
  input  logic             cu_hlt,
  input  logic             cu_reset,
  input  logic             cu_inSignal,
  input  logic             br_cond,
  input  logic [OFF_W-1:0] br_offset,
  input  logic [TGT_W-1:0] jmp_target,
  input  logic [31:0]      rs_data,
  input  logic             in_valid,
  input  logic             resume,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  pc_plus1,
  output logic             stall,
  output logic             in_ack,
  output logic             halted,
  output logic [31:0]      retired
);

  seq_state_e      r_state;
  seq_state_e      w_stateNext;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pcNext;
  logic [PC_W-1:0] w_pcPlus1;
  logic [PC_W-1:0] w_pcTarget;
  logic [31:0]     r_retired;
  logic            w_stall;
  logic            w_inAck;
  logic            w_retClr;

  pc_next_mux #(
    .PC_W (PC_W),
    .OFF_W(OFF_W),
    .TGT_W(TGT_W)
  ) u_nextMux (
    .i_pc       (r_pc),
    .i_jump     (cu_Jump),
    .i_branch   (cu_Branch),
    .i_brCond   (br_cond),
    .i_brOffset (br_offset),
    .i_jmpTarget(jmp_target),
    .i_rsData   (rs_data),
    .o_pcPlus1  (w_pcPlus1),
    .o_pcTarget (w_pcTarget)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_RUN;
      r_pc      <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_stateNext;
      r_pc    <= w_pcNext;
      if (w_retClr) begin
        r_retired <= '0;
      end else if (!w_stall) begin
        r_retired <= r_retired + 32'd1;
      end
    end
  end

  // Priority chain lets lower-priority controls be don't-care without leaking into outputs.
  always_comb begin
    w_stateNext = r_state;
    w_pcNext    = r_pc;
    w_stall     = 1'b1;
    w_inAck     = 1'b0;
    w_retClr    = 1'b0;
    if (rst_n) begin
      case (r_state)
        ST_RUN: begin
          if (cu_reset) begin
            w_pcNext = '0;
            w_retClr = 1'b1;
          end else if (cu_hlt) begin
            w_stateNext = ST_HALT;
          end else if (cu_inSignal) begin
            if (in_valid) begin
              w_inAck  = 1'b1;
              w_stall  = 1'b0;
              w_pcNext = w_pcPlus1;
            end else begin
              w_stateNext = ST_WAIT_IN;
            end
          end else begin
            w_stall  = 1'b0;
            w_pcNext = w_pcTarget;
          end
        end
        ST_WAIT_IN: begin
          if (in_valid) begin
            w_inAck     = 1'b1;
            w_stall     = 1'b0;
            w_pcNext    = w_pcPlus1;
            w_stateNext = ST_RUN;
          end
        end
        ST_HALT: begin
          if (resume) begin
            w_pcNext    = w_pcPlus1;
            w_stateNext = ST_RUN;
          end
        end
        default: w_stateNext = ST_RUN;
      endcase
    end
  end

  assign pc       = r_pc;
  assign pc_plus1 = w_pcPlus1;
  assign stall    = w_stall;
  assign in_ack   = w_inAck;
  assign halted   = (r_state == ST_HALT);
  assign retired  = r_retired;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  localparam int PC_W  = 10;
  localparam int OFF_W = 16;
  localparam int TGT_W = 26;
  localparam int PC_MASK = (1 << PC_W) - 1;
  localparam int M_RUN  = 0;
  localparam int M_HALT = 1;
  localparam int M_WAIT = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       cu_Jump;
  logic             cu_Branch, cu_hlt, cu_reset, cu_inSignal, br_cond;
  logic [OFF_W-1:0] br_offset;
  logic [TGT_W-1:0] jmp_target;
  logic [31:0]      rs_data;
  logic             in_valid, resume;
  logic [PC_W-1:0]  pc, pc_plus1;
  logic             stall, in_ack, halted;
  logic [31:0]      retired;

  int          checks = 0;
  int          errors = 0;
  bit          checkEn = 1'b0;
  int          mPc = 0;
  int          mMode = M_RUN;
  logic [31:0] mRet = '0;
  logic [31:0] rSave;

  always #5 clk = ~clk;

  pc_sequencer #(.PC_W(PC_W), .OFF_W(OFF_W), .TGT_W(TGT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cu_Jump(cu_Jump), .cu_Branch(cu_Branch),
    .cu_hlt(cu_hlt), .cu_reset(cu_reset), .cu_inSignal(cu_inSignal),
    .br_cond(br_cond), .br_offset(br_offset), .jmp_target(jmp_target),
    .rs_data(rs_data), .in_valid(in_valid), .resume(resume), .pc(pc),
    .pc_plus1(pc_plus1), .stall(stall), .in_ack(in_ack), .halted(halted),
    .retired(retired)
  );

  // Model: what the sequencer must do this cycle, from the operating rules.
  function automatic bit expStall();
    if (!rst_n) return 1'b1;
    if (mMode == M_HALT) return 1'b1;
    if (mMode == M_WAIT) return !in_valid;
    if (cu_reset || cu_hlt) return 1'b1;
    if (cu_inSignal) return !in_valid;
    return 1'b0;
  endfunction

  function automatic bit expAck();
    if (!rst_n) return 1'b0;
    if (mMode == M_WAIT) return in_valid;
    if (mMode == M_RUN) return !cu_reset && !cu_hlt && cu_inSignal && in_valid;
    return 1'b0;
  endfunction

  function automatic int runNext();
    if (cu_Jump == 2'b01) return int'(jmp_target[PC_W-1:0]);
    if (cu_Jump == 2'b10) return int'(rs_data[PC_W-1:0]);
    if (cu_Branch && br_cond) return (mPc + 1 + int'($signed(br_offset))) & PC_MASK;
    return (mPc + 1) & PC_MASK;
  endfunction

  always @(posedge clk) begin
    bit st;
    st = expStall();
    if (!rst_n) begin
      mPc = 0; mMode = M_RUN; mRet = '0;
    end else begin
      if (!st) mRet = mRet + 32'd1;
      if (mMode == M_WAIT) begin
        if (in_valid) begin mPc = (mPc + 1) & PC_MASK; mMode = M_RUN; end
      end else if (mMode == M_HALT) begin
        if (resume) begin mPc = (mPc + 1) & PC_MASK; mMode = M_RUN; end
      end else if (cu_reset) begin
        mPc = 0; mRet = '0;
      end else if (cu_hlt) begin
        mMode = M_HALT;
      end else if (cu_inSignal) begin
        if (in_valid) mPc = (mPc + 1) & PC_MASK;
        else mMode = M_WAIT;
      end else begin
        mPc = runNext();
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("m_pc", 32'(pc), 32'(mPc));
      checkOutput("m_pc_plus1", 32'(pc_plus1), 32'((mPc + 1) & PC_MASK));
      checkOutput("m_stall", 32'(stall), 32'(expStall()));
      checkOutput("m_in_ack", 32'(in_ack), 32'(expAck()));
      checkOutput("m_halted", 32'(halted), 32'(mMode == M_HALT));
      checkOutput("m_retired", retired, mRet);
    end
  end

  task automatic clearInputs();
    rst_n = 1'b1; cu_Jump = 2'b00; cu_Branch = 1'b0; cu_hlt = 1'b0;
    cu_reset = 1'b0; cu_inSignal = 1'b0; br_cond = 1'b0; br_offset = '0;
    jmp_target = '0; rs_data = '0; in_valid = 1'b0; resume = 1'b0;
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic jumpTo(input int target);
    clearInputs();
    cu_Jump = 2'b01;
    jmp_target = TGT_W'(target);
    applyStimulus(1);
    clearInputs();
  endtask

  initial begin
    clearInputs();
    rst_n = 1'b0;
    applyStimulus(2);
    checkEn = 1'b1;
    in_valid = 1'b1;
    #1;
    checkOutput("rst_pc", 32'(pc), 32'd0);
    checkOutput("rst_retired", retired, 32'd0);
    checkOutput("rst_halted", 32'(halted), 32'd0);
    checkOutput("rst_stall", 32'(stall), 32'd1);
    checkOutput("rst_in_ack", 32'(in_ack), 32'd0);

    clearInputs();
    applyStimulus(5);
    checkOutput("seq_pc", 32'(pc), 32'd5);
    checkOutput("seq_retired", retired, 32'd5);
    checkOutput("seq_stall", 32'(stall), 32'd0);

    jumpTo(8);
    cu_Branch = 1'b1; br_cond = 1'b1; br_offset = 16'hFFFD;
    applyStimulus(1);
    checkOutput("br_taken_pc", 32'(pc), 32'd6);
    jumpTo(8);
    cu_Branch = 1'b1; br_cond = 1'b0; br_offset = 16'hFFFD;
    applyStimulus(1);
    checkOutput("br_not_taken_pc", 32'(pc), 32'd9);

    jumpTo(26'h3FF_0123);
    checkOutput("jmp_imm_pc", 32'(pc), 32'h123);
    cu_Jump = 2'b10; rs_data = 32'h20;
    #1;
    checkOutput("jmp_reg_link", 32'(pc_plus1), 32'h124);
    applyStimulus(1);
    checkOutput("jmp_reg_pc", 32'(pc), 32'h20);

    jumpTo(4);
    rSave = retired;
    cu_inSignal = 1'b1;
    #1;
    checkOutput("in_stall0", 32'(stall), 32'd1);
    applyStimulus(1);
    clearInputs();
    checkOutput("in_wait_pc", 32'(pc), 32'd4);
    for (int i = 0; i < 2; i++) begin
      #1;
      checkOutput("in_stall_wait", 32'(stall), 32'd1);
      checkOutput("in_ack_wait", 32'(in_ack), 32'd0);
      applyStimulus(1);
    end
    in_valid = 1'b1;
    #1;
    checkOutput("in_ack_pulse", 32'(in_ack), 32'd1);
    checkOutput("in_ack_stall", 32'(stall), 32'd0);
    applyStimulus(1);
    clearInputs();
    checkOutput("in_done_pc", 32'(pc), 32'd5);
    checkOutput("in_retired", retired, rSave + 32'd1);

    jumpTo(7);
    cu_Jump = 2'($urandom_range(0, 3));
    cu_Branch = 1'($urandom_range(0, 1));
    cu_hlt = 1'b1;
    applyStimulus(1);
    clearInputs();
    checkOutput("hlt_halted", 32'(halted), 32'd1);
    rSave = retired;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      applyStimulus(1);
      checkOutput("hlt_pc_hold", 32'(pc), 32'd7);
    end
    in_valid = 1'b0;
    resume = 1'b1;
    #1;
    checkOutput("resume_stall", 32'(stall), 32'd1);
    applyStimulus(1);
    clearInputs();
    checkOutput("resume_pc", 32'(pc), 32'd8);
    checkOutput("resume_halted", 32'(halted), 32'd0);
    checkOutput("resume_retired", retired, rSave);

    jumpTo(30);
    cu_reset = 1'b1;
    cu_Jump = 2'($urandom_range(0, 3));
    applyStimulus(1);
    clearInputs();
    checkOutput("swrst_pc", 32'(pc), 32'd0);
    checkOutput("swrst_retired", retired, 32'd0);

    applyStimulus(2);
    cu_inSignal = 1'b1;
    applyStimulus(1);
    clearInputs();
    applyStimulus(1);
    rst_n = 1'b0;
    in_valid = 1'b1;
    #1;
    checkOutput("hwrst_no_ack", 32'(in_ack), 32'd0);
    applyStimulus(1);
    checkOutput("hwrst_pc", 32'(pc), 32'd0);
    clearInputs();
    #1;
    checkOutput("hwrst_run_stall", 32'(stall), 32'd0);
    applyStimulus(1);
    checkOutput("hwrst_run_pc", 32'(pc), 32'd1);

    for (int n = 0; n < 1500; n++) begin
      clearInputs();
      rst_n       = ($urandom_range(0, 149) != 0);
      cu_reset    = ($urandom_range(0, 49) == 0);
      cu_hlt      = ($urandom_range(0, 19) == 0);
      cu_inSignal = ($urandom_range(0, 11) == 0);
      cu_Jump     = 2'($urandom_range(0, 3));
      cu_Branch   = (cu_Jump == 2'b11) ? 1'b0 : 1'($urandom_range(0, 1));
      br_cond     = 1'($urandom_range(0, 1));
      br_offset   = 16'($urandom);
      jmp_target  = 26'($urandom);
      rs_data     = $urandom;
      in_valid    = ($urandom_range(0, 2) == 0);
      resume      = ($urandom_range(0, 3) == 0);
      applyStimulus(1);
    end

    clearInputs();
    applyStimulus(1);
    checkEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
